// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode-side read, writeback and issue signals of the scoreboarded register file.
interface regfile_sb_if #(
    parameter int WIDTH        = 16,
    parameter int ADDRESSWIDTH = 4
);
    logic [ADDRESSWIDTH-1:0] ra1, ra2;
    logic [WIDTH-1:0]        PC;
    logic [WIDTH-1:0]        rd1, rd2;
    logic                    we3, we4;
    logic [ADDRESSWIDTH-1:0] wa3, wa4;
    logic [WIDTH-1:0]        wd3, wd4;
    logic                    issue_valid, issue_dst_en, issue_use1, issue_use2;
    logic [ADDRESSWIDTH-1:0] issue_dst;
    logic                    stall;
    logic [ADDRESSWIDTH:0]   busy_count;

    modport master (
        output ra1, ra2, PC, we3, wa3, wd3, we4, wa4, wd4,
               issue_valid, issue_dst_en, issue_dst, issue_use1, issue_use2,
        input  rd1, rd2, stall, busy_count
    );
    modport slave (
        input  ra1, ra2, PC, we3, wa3, wd3, we4, wa4, wd4,
               issue_valid, issue_dst_en, issue_dst, issue_use1, issue_use2,
        output rd1, rd2, stall, busy_count
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: two-write/two-read register file with write bypass, PC alias on the top index
// and a busy-bit scoreboard that stalls decode on RAW/WAW hazards.
module regfile_sb #(
    parameter int WIDTH        = 16,
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4,
    parameter int PCREG        = REGNUM - 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sb_if.slave bus
);
    localparam logic [ADDRESSWIDTH-1:0] pc_addr = ADDRESSWIDTH'(PCREG);

    logic [WIDTH-1:0]      rf_q [REGNUM];
    logic [REGNUM-1:0]     busy_q, busy_d, clr, ebusy, set;
    logic [ADDRESSWIDTH:0] busy_count_q, busy_count_d;

    always_comb begin
        clr = '0;
        for (int i = 0; i < REGNUM; i++)
            clr[i] = (bus.we3 && bus.wa3 == ADDRESSWIDTH'(i)) || (bus.we4 && bus.wa4 == ADDRESSWIDTH'(i));
        ebusy = busy_q & ~clr;
        ebusy[PCREG] = 1'b0;
    end

    assign bus.stall = bus.issue_valid && ((bus.issue_use1 && ebusy[bus.ra1]) ||
                                           (bus.issue_use2 && ebusy[bus.ra2]) ||
                                           (bus.issue_dst_en && ebusy[bus.issue_dst]));

    // A new producer issued on the same edge as the old one's writeback keeps the bit set.
    always_comb begin
        set = '0;
        for (int i = 0; i < REGNUM; i++)
            set[i] = bus.issue_valid && bus.issue_dst_en && !bus.stall &&
                     bus.issue_dst == ADDRESSWIDTH'(i) && i != PCREG;
        busy_d = (busy_q & ~clr) | set;
        busy_count_d = '0;
        for (int i = 0; i < REGNUM; i++)
            busy_count_d = busy_count_d + (ADDRESSWIDTH+1)'(busy_d[i]);
    end

    assign bus.rd1 = bus.ra1 == pc_addr                   ? bus.PC  :
                     (bus.we4 && bus.wa4 == bus.ra1)       ? bus.wd4 :
                     (bus.we3 && bus.wa3 == bus.ra1)       ? bus.wd3 : rf_q[bus.ra1];
    assign bus.rd2 = bus.ra2 == pc_addr                   ? bus.PC  :
                     (bus.we4 && bus.wa4 == bus.ra2)       ? bus.wd4 :
                     (bus.we3 && bus.wa3 == bus.ra2)       ? bus.wd3 : rf_q[bus.ra2];
    assign bus.busy_count = busy_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGNUM; i++) rf_q[i] <= '0;
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            if (bus.we3 && bus.wa3 != pc_addr) rf_q[bus.wa3] <= bus.wd3;
            if (bus.we4 && bus.wa4 != pc_addr) rf_q[bus.wa4] <= bus.wd4;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors with hand-computed expectations for regfile_sb.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    regfile_sb_if #(.WIDTH(16), .ADDRESSWIDTH(4)) bus ();
    regfile_sb #(.WIDTH(16), .REGNUM(16), .ADDRESSWIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we3 = 0; bus.we4 = 0; bus.wa3 = 0; bus.wa4 = 0; bus.wd3 = 0; bus.wd4 = 0;
        bus.issue_valid = 0; bus.issue_dst_en = 0; bus.issue_dst = 0;
        bus.issue_use1 = 0; bus.issue_use2 = 0;
    endtask

    task automatic issue(input logic [3:0] dst, input logic dst_en, input logic u1, input logic u2);
        bus.issue_valid = 1; bus.issue_dst = dst; bus.issue_dst_en = dst_en;
        bus.issue_use1 = u1; bus.issue_use2 = u2;
    endtask

    initial begin
        idle();
        bus.ra1 = 0; bus.ra2 = 0; bus.PC = 16'h0040;
        #12 rst_n = 1;
        tick();
        chk("reset_rd1", bus.rd1, 16'h0000);
        chk("reset_count", bus.busy_count, 0);
        chk("reset_stall", bus.stall, 0);

        // write r3 while a new producer for r3 issues: data stored, busy set
        bus.we3 = 1; bus.wa3 = 3; bus.wd3 = 16'hBEEF; issue(3, 1, 0, 0);
        tick(); idle(); bus.ra1 = 3; #1;
        chk("r3_stored", bus.rd1, 16'hBEEF);
        chk("r3_busy_count", bus.busy_count, 1);
        #1 rst_n = 0; #1;
        chk("async_rst_rd1", bus.rd1, 16'h0000);
        chk("async_rst_count", bus.busy_count, 0);
        rst_n = 1;
        tick();

        // dual-port write priority and bypass
        bus.we3 = 1; bus.wa3 = 5; bus.wd3 = 16'h1111;
        bus.we4 = 1; bus.wa4 = 5; bus.wd4 = 16'h2222;
        bus.ra1 = 5; bus.ra2 = 5; #1;
        chk("byp_b_rd1", bus.rd1, 16'h2222);
        chk("byp_b_rd2", bus.rd2, 16'h2222);
        tick(); idle(); #1;
        chk("b_wins_stored", bus.rd1, 16'h2222);
        bus.we3 = 1; bus.wa3 = 6; bus.wd3 = 16'h3333; bus.ra1 = 6; #1;
        chk("byp_a_rd1", bus.rd1, 16'h3333);
        chk("byp_a_other", bus.rd2, 16'h2222);
        tick(); idle(); #1;
        chk("a_stored", bus.rd1, 16'h3333);

        // PC alias
        bus.ra2 = 15; bus.PC = 16'h0040; bus.we3 = 1; bus.wa3 = 15; bus.wd3 = 16'hFFFF; #1;
        chk("pc_before", bus.rd2, 16'h0040);
        tick(); idle(); #1;
        chk("pc_after", bus.rd2, 16'h0040);
        bus.PC = 16'h0044; #1;
        chk("pc_follow", bus.rd2, 16'h0044);
        issue(15, 1, 0, 0); #1;
        chk("pc_issue_stall", bus.stall, 0);
        tick(); idle(); #1;
        chk("pc_never_busy", bus.busy_count, 0);

        // RAW hazard
        issue(2, 1, 0, 0); #1;
        chk("raw_issue_stall", bus.stall, 0);
        tick(); idle(); #1;
        chk("raw_count1", bus.busy_count, 1);
        bus.ra1 = 2; issue(0, 0, 1, 0); #1;
        chk("raw_stall", bus.stall, 1);
        tick(); #1;
        chk("raw_hold_count", bus.busy_count, 1);
        bus.we3 = 1; bus.wa3 = 2; bus.wd3 = 16'hABCD; #1;
        chk("raw_wb_stall", bus.stall, 0);
        chk("raw_wb_rd1", bus.rd1, 16'hABCD);
        tick(); idle(); #1;
        chk("raw_count0", bus.busy_count, 0);
        chk("raw_stored", bus.rd1, 16'hABCD);

        // source 2 hazard and use gating
        issue(8, 1, 0, 0); tick(); idle(); bus.ra2 = 8;
        issue(0, 0, 0, 1); #1;
        chk("use2_stall", bus.stall, 1);
        bus.issue_use2 = 0; #1;
        chk("use2_gated", bus.stall, 0);
        bus.issue_use2 = 1; bus.we4 = 1; bus.wa4 = 8; bus.wd4 = 16'h0808; #1;
        chk("use2_wb_stall", bus.stall, 0);
        chk("use2_wb_rd2", bus.rd2, 16'h0808);
        tick(); idle(); #1;
        chk("use2_count0", bus.busy_count, 0);

        // simultaneous set and clear of r4
        issue(4, 1, 0, 0); tick(); idle(); #1;
        chk("sc_count1", bus.busy_count, 1);
        bus.we4 = 1; bus.wa4 = 4; bus.wd4 = 16'h4444; issue(4, 1, 0, 0); #1;
        chk("sc_stall", bus.stall, 0);
        tick(); idle(); #1;
        chk("sc_count_kept", bus.busy_count, 1);
        bus.ra1 = 4; issue(0, 0, 1, 0); #1;
        chk("sc_still_busy", bus.stall, 1);
        idle();

        // WAW hazard
        issue(7, 1, 0, 0); tick(); idle(); #1;
        chk("waw_count2", bus.busy_count, 2);
        issue(7, 1, 0, 0); #1;
        chk("waw_stall", bus.stall, 1);
        tick(); idle(); #1;
        chk("waw_no_inc", bus.busy_count, 2);

        // reset mid-operation clears scoreboard
        #1 rst_n = 0; #1;
        chk("mid_rst_count", bus.busy_count, 0);
        bus.ra1 = 7; issue(0, 0, 1, 0); #1;
        chk("mid_rst_stall", bus.stall, 0);
        rst_n = 1; idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
